// File: rtl/seg_monitor_pkg.sv
// seg_monitor_pkg: shared seven-segment tables, invalid marker and FSM state type
// Contents: SEG_INVALID decode marker, SEG_ENC digit->pattern table (also used by the
// display path), state_e monitor states, seg_to_digit() pattern->digit lookup.
package seg_monitor_pkg;

    localparam logic [3:0] SEG_INVALID = 4'hF;

    // Active-high segments, bit0=a ... bit6=g
    localparam logic [6:0] SEG_ENC [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    typedef enum logic [1:0] {ST_EMPTY, ST_FIRST, ST_TRACK} state_e;

    function automatic logic [3:0] seg_to_digit(input logic [6:0] s);
        logic [3:0] d;
        d = SEG_INVALID;
        for (int i = 0; i < 10; i++)
            if (s == SEG_ENC[i]) d = 4'(i);
        return d;
    endfunction

endpackage

// File: rtl/seg_monitor_decode.sv
// seg_decode: combinational seven-segment pattern to decimal digit decoder
// Ports: seg (pattern in), digit (decoded digit, SEG_INVALID if unknown), valid (pattern is a digit)
module seg_decode
    import seg_monitor_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       valid
);

    assign digit = seg_to_digit(seg);
    assign valid = digit != SEG_INVALID;

endmodule

// File: rtl/seg_monitor.sv
// seg_monitor: watches a seven-segment digit, debounces it, checks count sequence and step rate
// Ports: clk, rst_n (async active-low), seg (observed pattern), clear_err (clear sticky flags);
//        digit/digit_valid/digit_tick (accepted digit), period (cycles between last two ticks),
//        seq_err/rate_err/invalid_err (sticky error flags).
module seg_monitor
    import seg_monitor_pkg::*;
#(
    parameter int CLOCK_FREQ    = 10_000,
    parameter int STABLE_CYCLES = 4,
    parameter int RATE_TOL      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic        clear_err,
    output logic [3:0]  digit,
    output logic        digit_valid,
    output logic        digit_tick,
    output logic [31:0] period,
    output logic        seq_err,
    output logic        rate_err,
    output logic        invalid_err
);

    localparam logic [7:0]  STABLE = 8'(STABLE_CYCLES);
    localparam logic [31:0] FREQ   = 32'(CLOCK_FREQ);
    localparam logic [31:0] TOL    = 32'(RATE_TOL);

    logic [6:0]  seg_q, cand_q, cand_d, pat_q, pat_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d, tick_q, tick_d;
    state_e      state_q, state_d;
    logic [3:0]  digit_q, digit_d, pat_digit, next_digit;
    logic [31:0] period_q, period_d, ivl_q, ivl_d, span, dev;
    logic        seq_q, seq_d, rate_q, rate_d, inv_q, inv_d;
    logic        diff, reach, want, accept, pat_valid;

    seg_decode u_dec (
        .seg   (pat_q),
        .digit (pat_digit),
        .valid (pat_valid)
    );

    always_comb begin
        diff       = seg_q != cand_q;
        cand_d     = seg_q;
        cnt_d      = diff ? 8'd1 : (cnt_q == STABLE ? STABLE : cnt_q + 8'd1);
        // Settled exactly once: on a fresh load, or on the step that brings the count to STABLE
        reach      = cnt_d == STABLE && (diff || cnt_q != STABLE);
        want       = pend_q && pat_valid && (state_q == ST_EMPTY || pat_digit != digit_q);
        // A settle landing right after a tick is held one cycle so ticks never abut
        accept     = want && !tick_q;
        pend_d     = reach || (want && tick_q);
        pat_d      = reach ? cand_d : pat_q;
        span       = &ivl_q ? ivl_q : ivl_q + 32'd1;
        dev        = span > FREQ ? span - FREQ : FREQ - span;
        next_digit = digit_q == 4'd9 ? 4'd0 : digit_q + 4'd1;
        state_d    = accept ? (state_q == ST_EMPTY ? ST_FIRST : ST_TRACK) : state_q;
        digit_d    = accept ? pat_digit : digit_q;
        tick_d     = accept;
        period_d   = (accept && state_q != ST_EMPTY) ? span : period_q;
        ivl_d      = accept ? 32'd0 : span;
        seq_d      = (accept && state_q != ST_EMPTY && pat_digit != next_digit) || (seq_q && !clear_err);
        rate_d     = (accept && state_q == ST_TRACK && dev > TOL) || (rate_q && !clear_err);
        inv_d      = (pend_q && !pat_valid) || (inv_q && !clear_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q    <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            pat_q    <= '0;
            state_q  <= ST_EMPTY;
            digit_q  <= '0;
            tick_q   <= 1'b0;
            period_q <= '0;
            ivl_q    <= '0;
            seq_q    <= 1'b0;
            rate_q   <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            seg_q    <= seg;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            pat_q    <= pat_d;
            state_q  <= state_d;
            digit_q  <= digit_d;
            tick_q   <= tick_d;
            period_q <= period_d;
            ivl_q    <= ivl_d;
            seq_q    <= seq_d;
            rate_q   <= rate_d;
            inv_q    <= inv_d;
        end
    end

    assign digit       = digit_q;
    assign digit_valid = state_q != ST_EMPTY;
    assign digit_tick  = tick_q;
    assign period      = period_q;
    assign seq_err     = seq_q;
    assign rate_err    = rate_q;
    assign invalid_err = inv_q;

endmodule

// File: tb/tb_seg_monitor.sv
// tb_seg_monitor: directed stimulus with a cycle-level reference model and literal spot checks
module tb_seg_monitor;

    localparam int CF  = 100;
    localparam int S   = 4;
    localparam int TOL = 2;

    logic        clk = 1'b0;
    logic        rst_n, clear_err;
    logic [6:0]  seg;
    logic [3:0]  digit;
    logic        digit_valid, digit_tick, seq_err, rate_err, invalid_err;
    logic [31:0] period;

    logic [6:0] enc [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int errors = 0;
    int checks = 0;
    int n_obs  = 0;

    seg_monitor #(.CLOCK_FREQ(CF), .STABLE_CYCLES(S), .RATE_TOL(TOL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .clear_err   (clear_err),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_tick  (digit_tick),
        .period      (period),
        .seq_err     (seq_err),
        .rate_err    (rate_err),
        .invalid_err (invalid_err)
    );

    always #5 clk = ~clk;

    function automatic int dec(input logic [6:0] p);
        case (p)
            7'h3F: return 0;
            7'h06: return 1;
            7'h5B: return 2;
            7'h4F: return 3;
            7'h66: return 4;
            7'h6D: return 5;
            7'h7D: return 6;
            7'h07: return 7;
            7'h7F: return 8;
            7'h6F: return 9;
            default: return 15;
        endcase
    endfunction

    // Reference model: counts runs of identical registered samples, and turns each
    // settled pattern into digit/period/flag updates from tick timestamps.
    int         cyc, m_run, m_digit, m_period, m_last, m_n, d;
    logic [6:0] m_prev, m_cand, m_pat, sample;
    logic       m_evt, m_valid, m_tick, m_seq, m_rate, m_inv, s_seq, s_rate, s_inv;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            cyc = 0; m_run = 0; m_digit = 0; m_period = 0; m_last = 0; m_n = 0;
            m_prev = '0; m_cand = '0; m_pat = '0; m_evt = 0; m_valid = 0; m_tick = 0;
            m_seq = 0; m_rate = 0; m_inv = 0;
        end else begin
            cyc++;
            s_seq = 0; s_rate = 0; s_inv = 0; m_tick = 0;
            if (m_evt) begin
                d = dec(m_pat);
                if (d > 9) s_inv = 1;
                else if (!m_valid || d != m_digit) begin
                    if (m_n >= 1) begin
                        m_period = cyc - m_last;
                        s_seq = d != (m_digit + 1) % 10;
                        s_rate = m_n >= 2 && (m_period > CF + TOL || m_period + TOL < CF);
                    end
                    m_digit = d; m_valid = 1; m_tick = 1; m_last = cyc; m_n++;
                end
            end
            m_seq  = s_seq  || (m_seq  && !clear_err);
            m_rate = s_rate || (m_rate && !clear_err);
            m_inv  = s_inv  || (m_inv  && !clear_err);
            sample = m_prev;
            m_prev = seg;
            m_evt  = 0;
            if (sample != m_cand) begin
                m_cand = sample; m_run = 1; m_evt = (S == 1);
            end else if (m_run < S) begin
                m_run++; m_evt = (m_run == S);
            end
            m_pat = m_cand;
        end
    end

    initial forever begin
        @(negedge clk);
        #1;
        checks++;
        if (digit_tick) n_obs++;
        if (digit !== 4'(m_digit) || digit_valid !== m_valid || digit_tick !== m_tick ||
            period !== 32'(m_period) || seq_err !== m_seq || rate_err !== m_rate || invalid_err !== m_inv) begin
            errors++;
            $display("FAIL model t=%0t got d=%0d v=%0b t=%0b p=%0d s=%0b r=%0b i=%0b want d=%0d v=%0b t=%0b p=%0d s=%0b r=%0b i=%0b",
                     $time, digit, digit_valid, digit_tick, period, seq_err, rate_err, invalid_err,
                     m_digit, m_valid, m_tick, m_period, m_seq, m_rate, m_inv);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    int  base;
    bit  got;

    initial begin
        rst_n = 1'b0; seg = '0; clear_err = 1'b0;
        wait_n(3);
        chk("rst_digit", 32'(digit), 0);
        chk("rst_valid", 32'(digit_valid), 0);
        chk("rst_period", period, 0);
        chk("rst_flags", 32'({seq_err, rate_err, invalid_err}), 0);
        rst_n = 1'b1;
        wait_n(1);
        seg = 7'h3F;
        wait_n(5);
        chk("first_pre_tick", 32'(digit_tick), 0);
        wait_n(1);
        chk("first_tick", 32'(digit_tick), 1);
        chk("first_digit", 32'(digit), 0);
        chk("first_valid", 32'(digit_valid), 1);
        chk("first_flags", 32'({seq_err, rate_err, invalid_err}), 0);
        wait_n(94);
        for (int k = 1; k <= 10; k++) begin
            seg = enc[k % 10];
            wait_n(100);
        end
        chk("count_ticks", 32'(n_obs), 11);
        chk("count_period", period, 100);
        chk("count_seq", 32'(seq_err), 0);
        chk("count_rate", 32'(rate_err), 0);
        chk("count_digit", 32'(digit), 0);
        base = n_obs;
        for (int i = 0; i < 20; i++) begin
            seg = (i % 2 == 1) ? 7'h3F : 7'h06;
            wait_n(1);
        end
        seg = 7'h06;
        chk("glitch_quiet", 32'(n_obs - base), 0);
        wait_n(5);
        chk("glitch_pre_tick", 32'(digit_tick), 0);
        wait_n(1);
        chk("glitch_tick", 32'(digit_tick), 1);
        wait_n(20);
        chk("glitch_one_tick", 32'(n_obs - base), 1);
        chk("glitch_digit", 32'(digit), 1);
        seg = 7'h5B;
        wait_n(50);
        clear_err = 1'b1;
        wait_n(1);
        clear_err = 1'b0;
        wait_n(49);
        seg = 7'h4F;
        wait_n(100);
        seg = 7'h6D;
        wait_n(100);
        chk("skip_seq", 32'(seq_err), 1);
        chk("skip_rate", 32'(rate_err), 0);
        wait_n(5);
        seg = 7'h7D;
        wait_n(10);
        chk("slow_period", period, 105);
        chk("slow_rate", 32'(rate_err), 1);
        clear_err = 1'b1;
        wait_n(1);
        clear_err = 1'b0;
        chk("clear_flags", 32'({seq_err, rate_err}), 0);
        base = n_obs;
        seg = 7'h49;
        wait_n(10);
        chk("inv_flag", 32'(invalid_err), 1);
        chk("inv_digit", 32'(digit), 6);
        chk("inv_no_tick", 32'(n_obs - base), 0);
        wait_n(20);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {digit, digit_valid, digit_tick, seq_err, rate_err, invalid_err, 21'd0}, 0);
        chk("mid_rst_period", period, 0);
        seg = 7'h7F;
        wait_n(1);
        rst_n = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            wait_n(1);
            if (digit_tick) got = 1;
        end
        chk("post_rst_tick", 32'(got), 1);
        chk("post_rst_digit", 32'(digit), 8);
        chk("post_rst_period", period, 0);
        chk("post_rst_seq", 32'(seq_err), 0);
        wait_n(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
